// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: adds two WIDTH-bit operands DIGIT bits
// per clock, LSB digit first, under a start/busy/done handshake.
// Ports:
//   clk       clock, all state updates on rising edge
//   rst_n     synchronous active-low reset
//   start     request, sampled only in IDLE or DONE
//   sub       0: in_1+in_2+c_in, 1: in_1+~in_2+1
//   in_1      operand A, latched on accepted start
//   in_2      operand B, latched on accepted start
//   c_in      carry-in, latched on accepted start (ignored when sub=1)
//   busy      high while the operation is running
//   done      one-cycle pulse, result registers valid
//   out       result, holds last completed result
//   c_out     carry out of MSB (subtract: 1 = no borrow)
//   overflow  signed overflow flag
//   zero      high when out == 0
module multicycle_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned DW    = DIGIT + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [SW-1:0]    step_q,     step_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic             carry_q,    carry_d;
    logic [WIDTH-1:0] part_q,     part_d;
    logic [WIDTH-1:0] out_d;
    logic             c_out_d, overflow_d, zero_d, busy_d, done_d;

    int unsigned      idx;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   dsum;
    logic             c_into_msb;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        part_d     = part_q;
        out_d      = out;
        c_out_d    = c_out;
        overflow_d = overflow;
        zero_d     = zero;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        idx   = int'(step_q) * DIGIT;
        a_dig = a_q[idx +: DIGIT];
        b_dig = b_q[idx +: DIGIT];
        dsum  = {1'b0, a_dig} + {1'b0, b_dig} + DW'(carry_q);
        // Carry into the digit MSB recovered from the sum bit and its operands
        c_into_msb = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = in_1;
                    b_d     = sub ? ~in_2 : in_2;
                    carry_d = sub ? 1'b1 : c_in;
                    step_d  = '0;
                    part_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                part_d[idx +: DIGIT] = dsum[DIGIT-1:0];
                carry_d = dsum[DIGIT];
                step_d  = step_q + SW'(1);
                if (step_q == SW'(STEPS - 1)) begin
                    out_d      = part_d;
                    c_out_d    = dsum[DIGIT];
                    overflow_d = c_into_msb ^ dsum[DIGIT];
                    zero_d     = (part_d == '0);
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            part_q   <= '0;
            out      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            part_q   <= part_d;
            out      <= out_d;
            c_out    <= c_out_d;
            overflow <= overflow_d;
            zero     <= zero_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
